// File: rtl/calfifo_pkg.sv
// Shared defaults and types for the calibrator FIFO controller slice.
// Consumers import calfifo_pkg::* and override per instance where needed.
package calfifo_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 128;
  localparam int DEF_AW        = 7;
  localparam int DEF_RAM_LAT   = 2;
  localparam int DEF_AFULL_TH  = 120;
  localparam int DEF_AEMPTY_TH = 8;

  // Occupancy needs one extra bit so a completely full FIFO (DEPTH) is representable.
  typedef logic [DEF_AW:0] count_t;

endpackage

// File: rtl/calfifo_sync_ctrl_if.sv
// User-side and RAM-side signal bundle of the calibrator FIFO controller.
// The controller uses the slave modport; the producer/consumer/RAM side uses master.
interface calfifo_sync_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 7
);

  logic             CLR;
  logic             WE;
  logic [WIDTH-1:0] WDATA;
  logic             RE;
  logic [WIDTH-1:0] RDATA;
  logic             RVALID;
  logic             FULL;
  logic             EMPTY;
  logic             AFULL;
  logic             AEMPTY;
  logic [AW:0]      COUNT;
  logic             WR_OVF;
  logic             RD_UNF;
  logic             RAM_WEN;
  logic [AW-1:0]    RAM_WADDR;
  logic [WIDTH-1:0] RAM_WDATA;
  logic             RAM_REN;
  logic [AW-1:0]    RAM_RADDR;
  logic [WIDTH-1:0] RAM_RDATA;

  modport slave (
    input  CLR, WE, WDATA, RE, RAM_RDATA,
    output RDATA, RVALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, WR_OVF, RD_UNF,
           RAM_WEN, RAM_WADDR, RAM_WDATA, RAM_REN, RAM_RADDR
  );

  modport master (
    output CLR, WE, WDATA, RE, RAM_RDATA,
    input  RDATA, RVALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, WR_OVF, RD_UNF,
           RAM_WEN, RAM_WADDR, RAM_WDATA, RAM_REN, RAM_RADDR
  );

endinterface

// File: rtl/calfifo_rvalid_pipe.sv
// Valid shift register that tracks accepted RAM reads through the RAM pipeline.
// A flush or reset empties every stage so in-flight reads never surface.
module calfifo_rvalid_pipe #(
  parameter int LAT = 2
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] stage;

  generate
    if (LAT == 1) begin : g_single
      always_ff @(posedge CLOCK) begin
        if (!RESET_N || flush) stage <= '0;
        else                   stage <= din;
      end
    end else begin : g_multi
      // NOTE: non-blocking assignments make every stage sample its pre-edge neighbour,
      // which is what turns this into a shift register instead of a wire.
      always_ff @(posedge CLOCK) begin
        if (!RESET_N || flush) stage <= '0;
        else                   stage <= {stage[LAT-2:0], din};
      end
    end
  endgenerate

  assign dout = stage[LAT-1];

endmodule

// File: rtl/calfifo_sync_ctrl.sv
// Single-clock FIFO controller sequencing a dual-port pipelined USRAM.
// Owns pointers, occupancy, flags, sticky errors and read-valid tracking.
module calfifo_sync_ctrl
  import calfifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AW        = DEF_AW,
  parameter int RAM_LAT   = DEF_RAM_LAT,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  calfifo_sync_ctrl_if.slave   bus
);

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          full;
  logic          empty;
  logic          afull;
  logic          aempty;
  logic          wr_ovf;
  logic          rd_unf;
  logic          live;
  logic          wa;
  logic          ra;
  logic          valid_q;

  // Requests are ignored outright while flushing or in reset.
  assign live = RESET_N & ~bus.CLR;
  assign wa   = live & bus.WE & ~full;
  assign ra   = live & bus.RE & ~empty;

  always_comb begin
    // NOTE: default first so no path leaves count_nxt unassigned (no latch).
    count_nxt = count;
    unique case ({wa, ra})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags come from count_nxt so they change in the same cycle as COUNT.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N || bus.CLR) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
      wr_ovf <= 1'b0;
      rd_unf <= 1'b0;
    end else begin
      if (wa) wptr <= wptr + AW'(1);
      if (ra) rptr <= rptr + AW'(1);
      count  <= count_nxt;
      full   <= (count_nxt == DEPTH_C);
      empty  <= (count_nxt == '0);
      afull  <= (count_nxt >= AFULL_C);
      aempty <= (count_nxt <= AEMPTY_C);
      if (bus.WE && full)  wr_ovf <= 1'b1;
      if (bus.RE && empty) rd_unf <= 1'b1;
    end
  end

  calfifo_rvalid_pipe #(
    .LAT (RAM_LAT)
  ) u_rvalid_pipe (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .flush   (bus.CLR),
    .din     (ra),
    .dout    (valid_q)
  );

  // A read landing in a flush/reset cycle belongs to the discarded stream.
  assign bus.RVALID    = valid_q & live;
  assign bus.RDATA     = bus.RAM_RDATA;

  assign bus.RAM_WEN   = wa;
  assign bus.RAM_WADDR = wptr;
  assign bus.RAM_WDATA = bus.WDATA;
  assign bus.RAM_REN   = ra;
  assign bus.RAM_RADDR = rptr;

  assign bus.COUNT     = count;
  assign bus.FULL      = full;
  assign bus.EMPTY     = empty;
  assign bus.AFULL     = afull;
  assign bus.AEMPTY    = aempty;
  assign bus.WR_OVF    = wr_ovf;
  assign bus.RD_UNF    = rd_unf;

endmodule

// File: tb/tb_calfifo_sync_ctrl.sv
// Self-checking bench for calfifo_sync_ctrl: queue-based FIFO model, pipelined RAM model,
// per-cycle comparison plus directed scenarios with literal expectations.
module tb_calfifo_sync_ctrl;
  import calfifo_pkg::*;

  localparam int WIDTH = DEF_WIDTH;
  localparam int DEPTH = DEF_DEPTH;
  localparam int AW    = DEF_AW;
  localparam int LAT   = DEF_RAM_LAT;

  logic CLOCK = 1'b0;
  logic RESET_N;

  calfifo_sync_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  calfifo_sync_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RAM_LAT(LAT),
    .AFULL_TH(DEF_AFULL_TH), .AEMPTY_TH(DEF_AEMPTY_TH)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pipelined RAM: data for an accepted read appears LAT edges later.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_pipe [LAT];
  always @(posedge CLOCK) begin
    if (bus.RAM_WEN === 1'b1) mem[bus.RAM_WADDR] <= bus.RAM_WDATA;
    if (bus.RAM_REN === 1'b1) rd_pipe[0] <= mem[bus.RAM_RADDR];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.RAM_RDATA = rd_pipe[LAT-1];

  // Behavioural FIFO model: contents as a queue, pending reads as (due cycle, data).
  typedef struct {
    int               due;
    logic [WIDTH-1:0] data;
  } pend_t;

  logic [WIDTH-1:0] m_q [$];
  pend_t            m_pend [$];
  int               m_wptr = 0;
  int               m_rptr = 0;
  bit               m_ovf = 0;
  bit               m_unf = 0;
  int               cyc = 0;
  bit               started = 0;

  always @(posedge CLOCK) begin
    bit               wa;
    bit               ra;
    pend_t            p;
    cyc++;
    if (!RESET_N || bus.CLR) begin
      m_q.delete();
      m_pend.delete();
      m_wptr = 0;
      m_rptr = 0;
      m_ovf  = 0;
      m_unf  = 0;
    end else begin
      wa = bus.WE && (m_q.size() < DEPTH);
      ra = bus.RE && (m_q.size() > 0);
      if (bus.WE && m_q.size() == DEPTH) m_ovf = 1;
      if (bus.RE && m_q.size() == 0)     m_unf = 1;
      if (ra) begin
        p.due  = cyc + LAT - 1;
        p.data = m_q.pop_front();
        m_pend.push_back(p);
        m_rptr = (m_rptr + 1) % DEPTH;
      end
      if (wa) begin
        m_q.push_back(bus.WDATA);
        m_wptr = (m_wptr + 1) % DEPTH;
      end
    end
  end

  logic [WIDTH-1:0] got [$];
  int prev_wa = -1, prev_ra = -1, wwrap = 0, rwrap = 0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK) begin
    count_t           cnt;
    bit               live;
    bit               exp_wen;
    bit               exp_ren;
    bit               exp_rv;
    logic [WIDTH-1:0] exp_d;
    if (started) begin
      cnt     = count_t'(m_q.size());
      live    = (RESET_N === 1'b1) && (bus.CLR === 1'b0);
      exp_wen = live && bus.WE && (m_q.size() < DEPTH);
      exp_ren = live && bus.RE && (m_q.size() > 0);
      check("count",  bus.COUNT,  cnt);
      check("full",   bus.FULL,   m_q.size() == DEPTH);
      check("empty",  bus.EMPTY,  m_q.size() == 0);
      check("afull",  bus.AFULL,  m_q.size() >= DEF_AFULL_TH);
      check("aempty", bus.AEMPTY, m_q.size() <= DEF_AEMPTY_TH);
      check("wr_ovf", bus.WR_OVF, m_ovf);
      check("rd_unf", bus.RD_UNF, m_unf);
      check("ram_wen", bus.RAM_WEN, exp_wen);
      check("ram_ren", bus.RAM_REN, exp_ren);
      if (exp_wen) begin
        check("ram_waddr", bus.RAM_WADDR, m_wptr);
        check("ram_wdata", bus.RAM_WDATA, bus.WDATA);
      end
      if (exp_ren) check("ram_raddr", bus.RAM_RADDR, m_rptr);
      exp_rv = 0;
      exp_d  = '0;
      if (m_pend.size() > 0 && m_pend[0].due == cyc) begin
        exp_rv = live;
        exp_d  = m_pend[0].data;
        m_pend.delete(0);
      end
      check("rvalid", bus.RVALID, exp_rv);
      if (exp_rv) check("rdata", bus.RDATA, exp_d);
      if (bus.RVALID === 1'b1) got.push_back(bus.RDATA);
      if (bus.RAM_WEN === 1'b1) begin
        if (prev_wa == DEPTH-1 && bus.RAM_WADDR == 0) wwrap++;
        prev_wa = int'(bus.RAM_WADDR);
      end
      if (bus.RAM_REN === 1'b1) begin
        if (prev_ra == DEPTH-1 && bus.RAM_RADDR == 0) rwrap++;
        prev_ra = int'(bus.RAM_RADDR);
      end
    end
  end

  task automatic tick(input logic we, input logic [WIDTH-1:0] wd, input logic re, input logic clr);
    bus.WE    = we;
    bus.WDATA = wd;
    bus.RE    = re;
    bus.CLR   = clr;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int budget;
    bus.WE = 0; bus.RE = 0; bus.CLR = 0; bus.WDATA = '0;
    RESET_N = 1'b0;
    @(posedge CLOCK); #1;
    started = 1;
    tick(1'b0, '0, 1'b0, 1'b0);
    RESET_N = 1'b1;

    // 1: reset state, five writes, five reads with 2-cycle latency
    check("rst_count",  bus.COUNT,  0);
    check("rst_empty",  bus.EMPTY,  1);
    check("rst_aempty", bus.AEMPTY, 1);
    check("rst_full",   bus.FULL,   0);
    check("rst_afull",  bus.AFULL,  0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_ovf",    bus.WR_OVF, 0);
    check("rst_unf",    bus.RD_UNF, 0);
    for (int i = 0; i < 5; i++) tick(1'b1, WIDTH'(32'h11 + i), 1'b0, 1'b0);
    check("t1_count5", bus.COUNT, 5);
    got.delete();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      check("t1_latency", bus.RVALID, (i >= 1));
    end
    idle(LAT + 1);
    check("t1_nread", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("t1_rdata", got[i], 32'h11 + i);
    check("t1_count0", bus.COUNT, 0);
    check("t1_empty",  bus.EMPTY, 1);

    // 2: fill to full, AFULL threshold, rejected 129th write
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, WIDTH'(32'h200 + i), 1'b0, 1'b0);
      if (i + 1 == 119) check("t2_afull_119", bus.AFULL, 0);
      if (i + 1 == 120) check("t2_afull_120", bus.AFULL, 1);
    end
    check("t2_full",  bus.FULL,  1);
    check("t2_count", bus.COUNT, 128);
    bus.WE = 1'b1; bus.RE = 1'b0; bus.WDATA = 32'hbad0;
    #1;
    check("t2_wen_rejected", bus.RAM_WEN, 0);
    tick(1'b1, 32'hbad0, 1'b0, 1'b0);
    check("t2_ovf",   bus.WR_OVF, 1);
    check("t2_count_hold", bus.COUNT, 128);

    // 3: simultaneous write/read while full, then drain
    got.delete();
    tick(1'b1, 32'hdead, 1'b1, 1'b0);
    check("t3_count", bus.COUNT, 127);
    check("t3_full",  bus.FULL,  0);
    check("t3_ovf",   bus.WR_OVF, 1);
    budget = 200;
    while (bus.EMPTY !== 1'b1 && budget > 0) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      budget--;
    end
    check("t3_drain_bound", budget > 0, 1);
    idle(LAT + 1);
    check("t3_nread", got.size(), 128);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== WIDTH'(32'h200 + i)) bad++;
    check("t3_order", bad, 0);

    // 4: pointer wrap with occupancy held between 1 and 10
    tick(1'b0, '0, 1'b0, 1'b1);
    check("t4_clr_ovf", bus.WR_OVF, 0);
    got.delete(); wwrap = 0; rwrap = 0;
    for (int i = 0; i < 5; i++)   tick(1'b1, WIDTH'(1000 + i), 1'b0, 1'b0);
    for (int i = 5; i < 300; i++) tick(1'b1, WIDTH'(1000 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)   tick(1'b0, '0, 1'b1, 1'b0);
    idle(LAT + 1);
    check("t4_nread", got.size(), 300);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== WIDTH'(1000 + i)) bad++;
    check("t4_order", bad, 0);
    check("t4_wwrap", wwrap, 2);
    check("t4_rwrap", rwrap, 2);
    check("t4_count", bus.COUNT, 0);

    // 5: read and write together while empty
    got.delete();
    tick(1'b1, 32'h55, 1'b1, 1'b0);
    check("t5_count",  bus.COUNT,  1);
    check("t5_unf",    bus.RD_UNF, 1);
    check("t5_aempty", bus.AEMPTY, 1);
    check("t5_empty",  bus.EMPTY,  0);
    idle(LAT + 1);
    check("t5_no_rvalid", got.size(), 0);

    // 6a: two reads in flight, then CLR
    for (int i = 0; i < 3; i++) tick(1'b1, WIDTH'(32'h61 + i), 1'b0, 1'b0);
    got.delete();
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    check("t6_clr_count", bus.COUNT,  0);
    check("t6_clr_empty", bus.EMPTY,  1);
    check("t6_clr_unf",   bus.RD_UNF, 0);
    check("t6_clr_ovf",   bus.WR_OVF, 0);
    idle(LAT + 1);
    check("t6_clr_no_rvalid", got.size(), 0);

    // 6b: same sequence ended by a reset pulse
    tick(1'b0, '0, 1'b1, 1'b0);
    check("t6_unf_set", bus.RD_UNF, 1);
    for (int i = 0; i < 3; i++) tick(1'b1, WIDTH'(32'h71 + i), 1'b0, 1'b0);
    got.delete();
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    RESET_N = 1'b0;
    tick(1'b0, '0, 1'b0, 1'b0);
    RESET_N = 1'b1;
    check("t6_rst_count",  bus.COUNT,  0);
    check("t6_rst_empty",  bus.EMPTY,  1);
    check("t6_rst_aempty", bus.AEMPTY, 1);
    check("t6_rst_unf",    bus.RD_UNF, 0);
    idle(LAT + 1);
    check("t6_rst_no_rvalid", got.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
